// File: rtl/coin_collector_if.sv
// Payment bus between the coin front end and the vend/refund stages.
// The slave modport is the coin_collector side.
interface coin_collector_if;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       cancel;
  logic [7:0] price;
  logic       vend_ack;
  logic       refund_ack;
  logic [7:0] amount_paid;
  logic       paid_ok;
  logic       coin_reject;
  logic       refund_valid;
  logic [7:0] refund_amount;
  logic [1:0] state;

  modport master (
    output coin_valid, coin_type, cancel, price, vend_ack, refund_ack,
    input  amount_paid, paid_ok, coin_reject, refund_valid, refund_amount, state
  );

  modport slave (
    input  coin_valid, coin_type, cancel, price, vend_ack, refund_ack,
    output amount_paid, paid_ok, coin_reject, refund_valid, refund_amount, state
  );
endinterface

// File: rtl/coin_collector.sv
// Vending payment front end: accumulates coin credit, holds it for the vend stage or refunds it.
// Optional idle timeout refund enabled by defining COIN_TIMEOUT_EN.
module coin_collector #(
  parameter int MAX_AMOUNT     = 250,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic             clk,
  input logic             reset,
  coin_collector_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    HOLD    = 2'b10,
    REFUND  = 2'b11
  } state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("coin_collector: TIMEOUT_CYCLES out of range 1..65535");
  end

  state_t     r_state;
  logic [7:0] r_amount;
  logic [7:0] r_refund_amt;
  logic       r_reject;
  logic       r_refund_vld;

  logic [8:0] w_coin;
  logic [8:0] w_sum;
  logic       w_fits;
  logic       w_paid_ok;
  logic       w_timeout;

  always_comb begin
    w_coin = 9'd1;
    case (bus.coin_type)
      2'b00: w_coin = 9'd1;
      2'b01: w_coin = 9'd5;
      2'b10: w_coin = 9'd10;
      2'b11: w_coin = 9'd25;
      default: w_coin = 9'd1;
    endcase
  end

  assign w_sum     = {1'b0, r_amount} + w_coin;
  assign w_fits    = (w_sum <= 9'(MAX_AMOUNT));
  assign w_paid_ok = (r_amount >= bus.price) && (bus.price != 8'd0);

`ifdef COIN_TIMEOUT_EN
  logic [15:0] r_idle_cnt;
  logic        w_coin_acc;

  // Counter only advances while we stay in COLLECT with nothing credited.
  assign w_coin_acc = bus.coin_valid && w_fits;
  assign w_timeout  = (r_state == COLLECT) && !w_coin_acc &&
                      (r_idle_cnt >= 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_idle_cnt <= 16'd0;
    else if (r_state == COLLECT && !bus.cancel && !w_timeout && !w_paid_ok && !w_coin_acc)
      r_idle_cnt <= r_idle_cnt + 16'd1;
    else
      r_idle_cnt <= 16'd0;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_amount     <= 8'd0;
      r_refund_amt <= 8'd0;
      r_reject     <= 1'b0;
      r_refund_vld <= 1'b0;
    end else begin
      r_reject <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.coin_valid) begin
            if (w_fits) begin
              r_amount <= w_sum[7:0];
              r_state  <= COLLECT;
            end else begin
              r_reject <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (bus.cancel || w_timeout) begin
            r_state      <= REFUND;
            r_refund_vld <= 1'b1;
            r_refund_amt <= r_amount;
            r_reject     <= bus.coin_valid;
          end else begin
            if (bus.coin_valid) begin
              if (w_fits) r_amount <= w_sum[7:0];
              else        r_reject <= 1'b1;
            end
            // Coin accepted on this edge is credited even though we leave COLLECT.
            if (w_paid_ok) r_state <= HOLD;
          end
        end
        HOLD: begin
          r_reject <= bus.coin_valid;
          if (bus.cancel) begin
            r_state      <= REFUND;
            r_refund_vld <= 1'b1;
            r_refund_amt <= r_amount;
          end else if (bus.vend_ack) begin
            r_amount <= 8'd0;
            r_state  <= IDLE;
          end else if (!w_paid_ok) begin
            r_state <= COLLECT;
          end
        end
        REFUND: begin
          r_reject <= bus.coin_valid;
          if (bus.refund_ack) begin
            r_amount     <= 8'd0;
            r_refund_amt <= 8'd0;
            r_refund_vld <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.amount_paid   = r_amount;
  assign bus.paid_ok       = w_paid_ok;
  assign bus.coin_reject   = r_reject;
  assign bus.refund_valid  = r_refund_vld;
  assign bus.refund_amount = r_refund_amt;
  assign bus.state         = r_state;

endmodule

// File: tb/tb_coin_collector.sv
// Self-checking bench for coin_collector: directed test-plan scenarios plus random traffic
// against a cycle-level credit/phase model. Timeout expectations follow COIN_TIMEOUT_EN.
module tb_coin_collector;
  localparam int MAXA = 250;
  localparam int TO   = 8;
  localparam int P_IDLE = 0, P_COLLECT = 1, P_HOLD = 2, P_REFUND = 3;

  logic clk = 1'b0;
  logic rst_n;
  coin_collector_if bus();

  coin_collector #(.MAX_AMOUNT(MAXA), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(rst_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int coin_tab[4] = '{1, 5, 10, 25};

  // model: credit, phase, refund request/amount, reject pulse, idle cycles in COLLECT
  int m_amt, m_ph, m_rv, m_ramt, m_rej, m_idle;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_amt = 0; m_ph = P_IDLE; m_rv = 0; m_ramt = 0; m_rej = 0; m_idle = 0;
  endtask

  task automatic check_all(input int pr);
    chk("amount_paid", int'(bus.amount_paid), m_amt);
    chk("state", int'(bus.state), m_ph);
    chk("coin_reject", int'(bus.coin_reject), m_rej);
    chk("refund_valid", int'(bus.refund_valid), m_rv);
    if (m_rv != 0) chk("refund_amount", int'(bus.refund_amount), m_ramt);
    chk("paid_ok", int'(bus.paid_ok), int'(m_amt >= pr && pr != 0));
  endtask

  // One clock: drive, check pre-edge outputs, step the model across the edge.
  task automatic cyc(input bit cv, input int ct, input bit cn, input int pr,
                     input bit va, input bit ra);
    int val, amt, ph, rv, ramt, rej, idle;
    bit pok, fits, tmo, credited;
    bus.coin_valid = cv; bus.coin_type = 2'(ct); bus.cancel = cn;
    bus.price = 8'(pr); bus.vend_ack = va; bus.refund_ack = ra;
    #1;
    check_all(pr);
    val = coin_tab[ct];
    pok = (m_amt >= pr) && (pr != 0);
    fits = (m_amt + val) <= MAXA;
    amt = m_amt; ph = m_ph; rv = m_rv; ramt = m_ramt; rej = 0; idle = 0;
    credited = 0;
`ifdef COIN_TIMEOUT_EN
    tmo = (m_ph == P_COLLECT) && !(cv && fits) && (m_idle + 1 >= TO);
`else
    tmo = 0;
`endif
    if (m_ph == P_IDLE) begin
      if (cv && fits) begin amt = val; ph = P_COLLECT; end
      else if (cv) rej = 1;
    end else if (m_ph == P_COLLECT) begin
      if (cn || tmo) begin
        ph = P_REFUND; rv = 1; ramt = m_amt; rej = int'(cv);
      end else begin
        if (cv && fits) begin amt = m_amt + val; credited = 1; end
        else if (cv) rej = 1;
        if (pok) ph = P_HOLD;
        else if (!credited) idle = m_idle + 1;
      end
    end else if (m_ph == P_HOLD) begin
      rej = int'(cv);
      if (cn) begin ph = P_REFUND; rv = 1; ramt = m_amt; end
      else if (va) begin amt = 0; ph = P_IDLE; end
      else if (!pok) ph = P_COLLECT;
    end else begin
      rej = int'(cv);
      if (ra) begin amt = 0; rv = 0; ramt = 0; ph = P_IDLE; end
    end
    @(posedge clk);
    #1;
    m_amt = amt; m_ph = ph; m_rv = rv; m_ramt = ramt; m_rej = rej; m_idle = idle;
  endtask

  task automatic idle_cyc(input int pr);
    cyc(1'b0, 0, 1'b0, pr, 1'b0, 1'b0);
  endtask

  task automatic coin(input int ct, input int pr);
    cyc(1'b1, ct, 1'b0, pr, 1'b0, 1'b0);
  endtask

  initial begin
    int pr;
    rst_n = 1'b0;
    bus.coin_valid = 0; bus.coin_type = 0; bus.cancel = 0;
    bus.price = 0; bus.vend_ack = 0; bus.refund_ack = 0;
    model_reset();
    #2;
    chk("rst_amount", int'(bus.amount_paid), 0);
    chk("rst_state", int'(bus.state), P_IDLE);
    chk("rst_reject", int'(bus.coin_reject), 0);
    chk("rst_refund_valid", int'(bus.refund_valid), 0);
    chk("rst_refund_amount", int'(bus.refund_amount), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 10,10,5 at price 20; the 5 lands in the HOLD-transition cycle
    coin(2, 20); chk("t1_amt10", int'(bus.amount_paid), 10);
    coin(2, 20); chk("t1_amt20", int'(bus.amount_paid), 20);
    coin(1, 20);
    chk("t1_amt25", int'(bus.amount_paid), 25);
    chk("t1_hold", int'(bus.state), P_HOLD);
    chk("t1_no_reject", int'(bus.coin_reject), 0);
    cyc(0, 0, 0, 20, 1, 0);
    chk("t1_vend_amt", int'(bus.amount_paid), 0);
    chk("t1_vend_idle", int'(bus.state), P_IDLE);

    // ceiling: 240 + 25 rejected, then +10 reaches 250
    repeat (9) coin(3, 250);
    coin(2, 250); coin(1, 250);
    chk("t2_amt240", int'(bus.amount_paid), 240);
    coin(3, 250);
    chk("t2_over_amt", int'(bus.amount_paid), 240);
    chk("t2_over_rej", int'(bus.coin_reject), 1);
    coin(2, 250);
    chk("t2_amt250", int'(bus.amount_paid), 250);
    chk("t2_rej_clear", int'(bus.coin_reject), 0);
    idle_cyc(250);
    chk("t2_hold", int'(bus.state), P_HOLD);
    cyc(0, 0, 1, 250, 0, 0);
    cyc(0, 0, 0, 250, 0, 1);

    // cancel with a coin at credit 35
    coin(3, 250); coin(2, 250);
    cyc(1, 2, 1, 250, 0, 0);
    chk("t3_rej", int'(bus.coin_reject), 1);
    chk("t3_refund_state", int'(bus.state), P_REFUND);
    chk("t3_refund_amt", int'(bus.refund_amount), 35);
    chk("t3_amt", int'(bus.amount_paid), 35);
    repeat (3) begin
      idle_cyc(250);
      chk("t3_rv_held", int'(bus.refund_valid), 1);
    end
    cyc(0, 0, 0, 250, 0, 1);
    chk("t3_ack_idle", int'(bus.state), P_IDLE);
    chk("t3_ack_amt", int'(bus.amount_paid), 0);
    chk("t3_ack_rv", int'(bus.refund_valid), 0);

    // price rises under HOLD
    coin(3, 30); coin(1, 30);
    idle_cyc(30);
    chk("t4_hold", int'(bus.state), P_HOLD);
    idle_cyc(40);
    chk("t4_back_collect", int'(bus.state), P_COLLECT);
    coin(2, 40);
    chk("t4_amt40", int'(bus.amount_paid), 40);
    idle_cyc(40);
    chk("t4_rehold", int'(bus.state), P_HOLD);
    cyc(0, 0, 0, 40, 1, 0);

    // inactivity after a single coin
    coin(1, 250);
    repeat (7) idle_cyc(250);
    chk("t5_still_collect", int'(bus.state), P_COLLECT);
    idle_cyc(250);
`ifdef COIN_TIMEOUT_EN
    chk("t5_timeout_refund", int'(bus.state), P_REFUND);
    chk("t5_timeout_amt", int'(bus.refund_amount), 5);
`else
    chk("t5_no_timeout", int'(bus.state), P_COLLECT);
    cyc(0, 0, 1, 250, 0, 0);
`endif
    cyc(0, 0, 0, 250, 0, 1);

    // asynchronous reset while refunding 50
    coin(3, 250); coin(3, 250);
    cyc(0, 0, 1, 250, 0, 0);
    chk("t6_refund_amt", int'(bus.refund_amount), 50);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rv", int'(bus.refund_valid), 0);
    chk("t6_rst_amt", int'(bus.amount_paid), 0);
    chk("t6_rst_state", int'(bus.state), P_IDLE);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic
    pr = 250;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 5))
          0: pr = 0;
          1: pr = 20;
          2: pr = 35;
          3: pr = 60;
          4: pr = 120;
          default: pr = 250;
        endcase
      end
      cyc(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
          ($urandom_range(0, 19) == 0), pr,
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/coin_collector.md
# coin_collector

Payment front end of the vending machine. Accepts coins one per cycle, accumulates a registered 8-bit `amount_paid`, and drives the main vending datapath, which derives change from `amount_paid` and the selected `price`. Holds the credit until the vend stage acknowledges the sale, or returns it through a refund handshake on cancel or inactivity timeout.

## Interface
Parameters:
- `MAX_AMOUNT`, default 250: credit ceiling; any coin that would push credit above it is rejected.
- `TIMEOUT_CYCLES`, default 1000: idle cycles allowed in COLLECT before an automatic refund. Valid range is 1..65535.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `coin_valid`  in  1  a coin is presented this cycle.
- `coin_type`  in  2  coin value code: 00=1, 01=5, 10=10, 11=25.
- `cancel`  in  1  customer cancel request, level-sampled.
- `price`  in  8  price of the selected product, from the price-register mux.
- `vend_ack`  in  1  vend stage has consumed the credit; honoured only in HOLD.
- `refund_ack`  in  1  refund dispenser has taken `refund_amount`.
- `amount_paid`  out  8  registered accumulated credit.
- `paid_ok`  out  1  combinational; high when `amount_paid >= price` and `price != 0`.
- `coin_reject`  out  1  registered one-cycle pulse; the coin presented in the previous cycle was not credited.
- `refund_valid`  out  1  refund request to the dispenser.
- `refund_amount`  out  8  credit being refunded; stable while `refund_valid` is high.
- `state`  out  2  FSM state: IDLE=00, COLLECT=01, HOLD=10, REFUND=11.

## Operation
- Coin value is zero-extended to 9 bits. Sum = `amount_paid` + value.
  - If sum > `MAX_AMOUNT`: the coin is rejected and credit is unchanged.
  - Otherwise: credit takes the sum.
- IDLE:
  - Credit is 0.
  - Accepted coin: move to COLLECT with credit = coin value.
  - `cancel`, `vend_ack` and `refund_ack` are ignored.
- COLLECT:
  - Coins are accumulated.
  - `cancel`: move to REFUND.
  - Else if `paid_ok` (evaluated on registered values): move to HOLD.
  - A coin accepted in the same cycle as the HOLD transition is still credited.
- HOLD:
  - All coins are rejected.
  - `vend_ack`: clear credit, move to IDLE.
  - `cancel` (wins over `vend_ack`): move to REFUND.
  - `price` rises so `paid_ok` drops: return to COLLECT.
- REFUND:
  - `refund_valid` = 1 and `refund_amount` = credit, frozen on entry. All coins are rejected.
  - `refund_ack`: clear credit, drop `refund_valid`, move to IDLE.
  - `cancel` is ignored.
- Simultaneous `coin_valid` and `cancel` in COLLECT: cancel wins, and the coin is rejected with a `coin_reject` pulse.
- Reset mid-operation discards all credit; there is no refund for credit lost to reset.

## Timing
- Reset values: `amount_paid`=0, `state`=IDLE, `coin_reject`=0, `refund_valid`=0, `refund_amount`=0, timeout counter=0.
- Credit latency is 1 cycle: a coin accepted at edge N appears on `amount_paid` after edge N.
- `coin_reject` is high for exactly the cycle after the rejected coin.
- `paid_ok` follows `amount_paid` and `price` combinationally. The HOLD transition lands one edge after `paid_ok` rises.
- `vend_ack` and `refund_ack` take effect at the sampling edge; credit reads 0 in the next cycle.
- Refund handshake: `refund_valid` stays high until the edge that samples `refund_ack`=1. Ack is allowed in the first REFUND cycle.

## Configuration
- `COIN_TIMEOUT_EN` defined:
  - A 16-bit counter runs in COLLECT.
  - It clears on every accepted coin and on any state change.
  - Reaching `TIMEOUT_CYCLES` without an accepted coin moves the FSM to REFUND exactly as a cancel would.
  - Rejected coins do not clear the counter.
- `COIN_TIMEOUT_EN` undefined:
  - No counter exists; COLLECT waits indefinitely.
  - Functionally identical otherwise.

## Test plan
- Reset low, then coins 10, 10, 5 with price=20 → `amount_paid` 10, 20, 25. FSM goes COLLECT→HOLD the cycle after credit 20. The third coin (5) is presented in that HOLD-transition cycle, so it is credited (25) with no `coin_reject`. Then `vend_ack` → credit 0, IDLE.
- Credit 240, coin 25 with `MAX_AMOUNT`=250 → credit stays 240 and `coin_reject` pulses for one cycle. A following coin 10 → credit 250.
- Credit 35 in COLLECT, `cancel` together with `coin_valid` → the coin is not credited, `coin_reject` pulses, REFUND with `refund_amount`=35. Holding `refund_ack` low for 3 cycles keeps `refund_valid` high. The ack edge → IDLE, credit 0.
- HOLD at credit 30 / price 30, then price changes to 40 → the FSM returns to COLLECT. A coin 10 → credit 40, and HOLD is re-entered.
- With `COIN_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8: a single coin 5, then silence → REFUND is entered 8 cycles after the coin, with `refund_amount`=5.
- Assert `reset` low while in REFUND with credit 50 → immediately `refund_valid`=0, `amount_paid`=0, `state`=IDLE, without waiting for a clock edge.
